vga_char_arbiter: RTL and testbench

// Shares the single Avalon-MM write master into the VGA character buffer between
// N_REQ on-chip text writers (score, status, game-over banner, ...). Round-robin

---
 rtl/vga_char_arbiter_if.sv | 27 ++
 rtl/vga_char_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vga_char_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_char_arbiter_if.sv
// Bundles the text-writer request side and the Avalon-MM character-buffer
// write master of vga_char_arbiter.
interface vga_char_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [7*N_REQ-1:0] req_x;
    logic [6*N_REQ-1:0] req_y;
    logic [8*N_REQ-1:0] req_char;
    logic [N_REQ-1:0]   req_ready;
    logic               clear_req;
    logic               clear_busy;
    logic [31:0]        vga_ch_address;
    logic               vga_ch_write;
    logic [15:0]        vga_ch_writedata;
    logic               vga_ch_waitrequest;

    modport slave (
        input  req_valid, req_x, req_y, req_char, clear_req, vga_ch_waitrequest,
        output req_ready, clear_busy, vga_ch_address, vga_ch_write, vga_ch_writedata
    );

    modport master (
        output req_valid, req_x, req_y, req_char, clear_req, vga_ch_waitrequest,
        input  req_ready, clear_busy, vga_ch_address, vga_ch_write, vga_ch_writedata
    );
endinterface

// File: rtl/vga_char_arbiter.sv
// Round-robin arbiter sharing one VGA character-buffer write master between
// N_REQ text writers, with a built-in full-screen clear sequencer.
module vga_char_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter logic [31:0] VGA_CH_BASE = 32'h0900_0000,
    parameter int unsigned COLS        = 80,
    parameter int unsigned ROWS        = 60,
    parameter logic [7:0]  CLEAR_CHAR  = 8'h20
) (
    input logic               clk,
    input logic               reset,
    vga_char_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  grant_q, grant_d;
    logic [6:0]     x_q, x_d;
    logic [5:0]     y_q, y_d;
    logic [7:0]     char_q, char_d;
    logic [6:0]     x_cnt_q, x_cnt_d;
    logic [5:0]     y_cnt_q, y_cnt_d;
    logic           clear_pend_q, clear_pend_d;

    logic [PW-1:0]  pick;
    logic           pick_vld;
    logic [6:0]     sel_x;
    logic [5:0]     sel_y;
    logic [7:0]     sel_char;
    logic           in_range;

    // Search starts just after the last granted requester so each pending
    // writer is served within N_REQ grants.
    always_comb begin
        int unsigned idx;
        logic [PW-1:0] cand;
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = PW'(idx);
            if (!pick_vld && bus.req_valid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_char = '0;
        for (int unsigned g = 0; g < N_REQ; g++) begin
            if (PW'(g) == pick) begin
                sel_x    = bus.req_x[7*g +: 7];
                sel_y    = bus.req_y[6*g +: 6];
                sel_char = bus.req_char[8*g +: 8];
            end
        end
    end

    assign in_range = (32'(x_q) < COLS) && (32'(y_q) < ROWS);

    always_comb begin
        state_d              = state_q;
        rr_ptr_d             = rr_ptr_q;
        grant_d              = grant_q;
        x_d                  = x_q;
        y_d                  = y_q;
        char_d               = char_q;
        x_cnt_d              = x_cnt_q;
        y_cnt_d              = y_cnt_q;
        clear_pend_d         = clear_pend_q;
        bus.req_ready        = '0;
        bus.vga_ch_write     = 1'b0;
        bus.vga_ch_address   = VGA_CH_BASE;
        bus.vga_ch_writedata = '0;
        bus.clear_busy       = clear_pend_q | (state_q == CLEAR);

        if (bus.clear_req && state_q != CLEAR) clear_pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (clear_pend_q) begin
                    state_d      = CLEAR;
                    x_cnt_d      = '0;
                    y_cnt_d      = '0;
                    clear_pend_d = 1'b0;
                end else if (pick_vld) begin
                    state_d = WRITE;
                    grant_d = pick;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    char_d  = sel_char;
                end
            end
            WRITE: begin
                if (in_range) begin
                    bus.vga_ch_write     = 1'b1;
                    bus.vga_ch_address   = VGA_CH_BASE | {19'b0, y_q, x_q};
                    bus.vga_ch_writedata = {8'h00, char_q};
                    if (!bus.vga_ch_waitrequest) begin
                        bus.req_ready[grant_q] = 1'b1;
                        rr_ptr_d               = grant_q;
                        state_d                = IDLE;
                    end
                end else begin
                    // Off-screen cell: acknowledge and drop without touching the bus.
                    bus.req_ready[grant_q] = 1'b1;
                    rr_ptr_d               = grant_q;
                    state_d                = IDLE;
                end
            end
            CLEAR: begin
                bus.vga_ch_write     = 1'b1;
                bus.vga_ch_address   = VGA_CH_BASE | {19'b0, y_cnt_q, x_cnt_q};
                bus.vga_ch_writedata = {8'h00, CLEAR_CHAR};
                if (!bus.vga_ch_waitrequest) begin
                    if (32'(x_cnt_q) == COLS - 1) begin
                        x_cnt_d = '0;
                        if (32'(y_cnt_q) == ROWS - 1) state_d = IDLE;
                        else y_cnt_d = y_cnt_q + 6'd1;
                    end else begin
                        x_cnt_d = x_cnt_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= PW'(N_REQ - 1);
            grant_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            char_q       <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            clear_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            x_q          <= x_d;
            y_q          <= y_d;
            char_q       <= char_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            clear_pend_q <= clear_pend_d;
        end
    end
endmodule

// File: tb/tb_vga_char_arbiter.sv
// Scoreboard bench for vga_char_arbiter: stimulus queues expected bus writes
// and grants, an independent monitor pops and compares them.
module tb_vga_char_arbiter;
    localparam logic [31:0] BASE = 32'h0900_0000;

    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_wr[$];
    int   exp_rdy[$];
    wr_t  mon_e;
    int   mon_g;

    vga_char_arbiter_if #(.N_REQ(4)) bus ();

    vga_char_arbiter #(.N_REQ(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int g, input logic [6:0] x, input logic [5:0] y, input logic [7:0] c);
        bus.req_x[7*g +: 7]    = x;
        bus.req_y[6*g +: 6]    = y;
        bus.req_char[8*g +: 8] = c;
        bus.req_valid[g]       = 1'b1;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] c);
        exp_wr.push_back('{a: a, d: {8'h00, c}});
    endtask

    task automatic push_clear();
        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 80; x++)
                push_wr(BASE | 32'(y * 128 + x), 8'h20);
    endtask

    // One iteration per clock; optionally releases a requester once served.
    task automatic run_until(input int n, input int max_cyc, input bit drop, output int first);
        logic [3:0] rdy;
        int got;
        int c;
        got   = 0;
        c     = 0;
        first = 0;
        while (got < n && c < max_cyc) begin
            @(negedge clk);
            c++;
            rdy = bus.req_ready;
            if (rdy != 4'b0) begin
                got++;
                if (first == 0) first = c;
            end
            @(posedge clk);
            #1;
            if (drop) bus.req_valid = bus.req_valid & ~rdy;
        end
        chk("ready_count", 32'(got), 32'(n));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.vga_ch_write && !bus.vga_ch_waitrequest) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual %h expected none", bus.vga_ch_address);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr", bus.vga_ch_address, mon_e.a);
                    chk("wr_data", 32'(bus.vga_ch_writedata), 32'(mon_e.d));
                end
            end
            if (bus.req_ready != 4'b0) begin
                chk("rdy_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                if (exp_rdy.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready actual %b expected none", bus.req_ready);
                end else begin
                    mon_g = exp_rdy.pop_front();
                    chk("rdy_grant", 32'(bus.req_ready), 32'(1) << mon_g);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int busy_bad;
        bus.req_valid          = '0;
        bus.req_x              = '0;
        bus.req_y              = '0;
        bus.req_char           = '0;
        bus.clear_req          = 1'b0;
        bus.vga_ch_waitrequest = 1'b0;

        // Reset values
        tick();
        tick();
        @(negedge clk);
        chk("rst_write", 32'(bus.vga_ch_write), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.clear_busy), 32'd0);
        chk("rst_addr", bus.vga_ch_address, BASE);
        chk("rst_data", 32'(bus.vga_ch_writedata), 32'd0);
        tick();
        rst = 1'b0;

        // 1: single write, ready in the second cycle of the request
        set_req(0, 7'd4, 6'd2, 8'h35);
        push_wr(32'h0900_0104, 8'h35);
        exp_rdy.push_back(0);
        run_until(1, 10, 1'b1, first);
        chk("t1_latency", 32'(first), 32'd2);

        // 2: requesters 1 and 3 held, alternate grants
        set_req(1, 7'd1, 6'd1, 8'h31);
        set_req(3, 7'd3, 6'd3, 8'h33);
        for (int i = 0; i < 3; i++) begin
            push_wr(32'h0900_0081, 8'h31);
            exp_rdy.push_back(1);
            push_wr(32'h0900_0183, 8'h33);
            exp_rdy.push_back(3);
        end
        run_until(6, 40, 1'b0, first);
        bus.req_valid = '0;

        // 3: waitrequest stall for 5 WRITE cycles
        set_req(2, 7'd10, 6'd5, 8'h41);
        bus.vga_ch_waitrequest = 1'b1;
        push_wr(32'h0900_028A, 8'h41);
        exp_rdy.push_back(2);
        @(negedge clk);
        chk("t3_idle_write", 32'(bus.vga_ch_write), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t3_write", 32'(bus.vga_ch_write), 32'd1);
            chk("t3_addr", bus.vga_ch_address, 32'h0900_028A);
            chk("t3_data", 32'(bus.vga_ch_writedata), 32'h0041);
            chk("t3_ready", 32'(bus.req_ready), (k == 6) ? 32'h4 : 32'h0);
            if (k == 5) begin
                @(posedge clk);
                #1;
                bus.vga_ch_waitrequest = 1'b0;
            end
        end
        tick();
        bus.req_valid[2] = 1'b0;

        // 5: x=80 and y=60 dropped without bus access; far corner still written
        set_req(0, 7'd0, 6'd60, 8'h11);
        set_req(1, 7'd80, 6'd0, 8'h22);
        set_req(2, 7'd79, 6'd59, 8'h5A);
        exp_rdy.push_back(0);
        exp_rdy.push_back(1);
        exp_rdy.push_back(2);
        push_wr(32'h0900_1DCF, 8'h5A);
        run_until(3, 30, 1'b1, first);

        // 4: clear takes priority over pending requester 2
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        set_req(2, 7'd1, 6'd1, 8'h42);
        push_clear();
        push_wr(32'h0900_0081, 8'h42);
        exp_rdy.push_back(2);
        busy_bad = 0;
        first    = 0;
        for (int c = 1; c <= 5000 && first == 0; c++) begin
            @(negedge clk);
            if (c <= 4801 && !bus.clear_busy) busy_bad++;
            if (c == 4802) chk("t4_busy_after", 32'(bus.clear_busy), 32'd0);
            if (bus.req_ready[2]) first = c;
            @(posedge clk);
            #1;
            if (first != 0) bus.req_valid[2] = 1'b0;
        end
        chk("t4_busy_hold", 32'(busy_bad), 32'd0);
        chk("t4_done_cycle", 32'(first), 32'd4803);
        chk("t4_queue_empty", 32'(exp_wr.size()), 32'd0);

        // 6: reset in the middle of a clear
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        push_clear();
        repeat (1000) tick();
        rst = 1'b1;
        exp_wr.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_write", 32'(bus.vga_ch_write), 32'd0);
        chk("t6_busy", 32'(bus.clear_busy), 32'd0);
        chk("t6_addr", bus.vga_ch_address, BASE);
        tick();
        set_req(0, 7'd2, 6'd3, 8'h30);
        set_req(3, 7'd5, 6'd6, 8'h33);
        push_wr(32'h0900_0182, 8'h30);
        exp_rdy.push_back(0);
        push_wr(32'h0900_0305, 8'h33);
        exp_rdy.push_back(3);
        run_until(2, 20, 1'b1, first);

        repeat (3) tick();
        chk("end_wr_queue", 32'(exp_wr.size()), 32'd0);
        chk("end_rdy_queue", 32'(exp_rdy.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
